cordic_atan2_iter: RTL and testbench

- Inverse of the sin/cos lookup ROM: takes a signed Cartesian pair (cos, sin), i.e. X/Y or I/Q, and returns the phase argument in the same unsigned full-circle format the ROM consumes (0..2^WIDTH-1 ↔ 0..2π), plus the CORDIC-scaled magnitude.
- Iterative (one micro-rotation per clock) CORDIC in vectoring mode with valid/ready handshakes on both sides.
- Used for phase recovery in NCO/demodulator loops and for loop-back checking of the ROM.

---
 rtl/cordic_atan2_iter_if.sv | 23 ++
 rtl/cordic_atan2_iter.sv | 143 ++++++++++++++
 tb/tb_cordic_atan2_iter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_atan2_iter_if.sv
// rtl/cordic_atan2_iter_if.sv - sample-in / result-out handshake bundle for the CORDIC atan2 block
interface cordic_atan2_iter_if #(
  parameter int WIDTH = 16
);
  logic                    i_valid;
  logic                    i_ready;
  logic signed [WIDTH-1:0] i_cos;
  logic signed [WIDTH-1:0] i_sin;
  logic                    o_valid;
  logic                    o_ready;
  logic [WIDTH-1:0]        o_arg;
  logic [WIDTH:0]          o_mag;

  modport master (
    output i_valid, i_cos, i_sin, o_ready,
    input  i_ready, o_valid, o_arg, o_mag
  );

  modport slave (
    input  i_valid, i_cos, i_sin, o_ready,
    output i_ready, o_valid, o_arg, o_mag
  );
endinterface

// File: rtl/cordic_atan2_iter.sv
// rtl/cordic_atan2_iter.sv - iterative vectoring-mode CORDIC returning full-circle phase and scaled magnitude
module cordic_atan2_iter #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16,
  parameter int GUARD = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clkena,
  cordic_atan2_iter_if.slave bus
);

  localparam int XW = WIDTH + 2;
  localparam int ZW = WIDTH + GUARD;
  localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  // Arctangent table in accumulator units (full circle = 2^ZW), rounded to nearest.
  function automatic logic [ITER*ZW-1:0] atan_table();
    logic [ITER*ZW-1:0] t;
    real                scale;
    longint             v;
    t     = '0;
    scale = (2.0 ** ZW) / (2.0 * 3.14159265358979323846);
    for (int i = 0; i < ITER; i++) begin
      v = longint'($atan(1.0 / (2.0 ** i)) * scale);
      t[i*ZW +: ZW] = v[ZW-1:0];
    end
    return t;
  endfunction

  localparam logic [ITER*ZW-1:0] ATAN_TAB = atan_table();

  state_t                state_q, state_d;
  logic signed [XW-1:0]  x_q, x_d;
  logic signed [XW-1:0]  y_q, y_d;
  logic [ZW-1:0]         z_q, z_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  zero_q, zero_d;

  logic signed [XW-1:0]  cos_ext;
  logic signed [XW-1:0]  sin_ext;
  logic signed [XW-1:0]  x_shift;
  logic signed [XW-1:0]  y_shift;
  logic [ZW-1:0]         atan_k;

  // Operand preparation: sign-extend inputs (two spare bits keep -(-2^(WIDTH-1)) and the K gain in range).
  always_comb begin
    cos_ext = {{2{bus.i_cos[WIDTH-1]}}, bus.i_cos};
    sin_ext = {{2{bus.i_sin[WIDTH-1]}}, bus.i_sin};
    x_shift = x_q >>> k_q;
    y_shift = y_q >>> k_q;
    atan_k  = ATAN_TAB[k_q*ZW +: ZW];
  end

  // Next-state and datapath: latch/pre-rotate in IDLE, one micro-rotation per enabled clock in ROTATE.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    k_d     = k_q;
    zero_d  = zero_q;
    if (clkena) begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            zero_d  = (bus.i_cos == '0) && (bus.i_sin == '0);
            k_d     = '0;
            state_d = ROTATE;
            if (bus.i_cos[WIDTH-1]) begin
              // Left half-plane: rotate by pi so the CORDIC only has to cover +-pi/2.
              x_d = -cos_ext;
              y_d = -sin_ext;
              z_d = {1'b1, {(ZW-1){1'b0}}};
            end else begin
              x_d = cos_ext;
              y_d = sin_ext;
              z_d = '0;
            end
          end
        end
        ROTATE: begin
          // A zero vector has no defined angle; freezing keeps o_arg=o_mag=0 with unchanged timing.
          if (!zero_q) begin
            if (!y_q[XW-1]) begin
              x_d = x_q + y_shift;
              y_d = y_q - x_shift;
              z_d = z_q + atan_k;
            end else begin
              x_d = x_q - y_shift;
              y_d = y_q + x_shift;
              z_d = z_q - atan_k;
            end
          end
          k_d = k_q + KW'(1);
          if (k_q == KW'(ITER - 1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.o_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; asynchronous reset aborts any sample in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      k_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      k_q     <= k_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs: rounding (z + half LSB) >> GUARD is the same as adding the bit just below the cut.
  always_comb begin
    bus.i_ready = (state_q == IDLE) && reset;
    bus.o_valid = (state_q == DONE);
    bus.o_arg   = '0;
    bus.o_mag   = '0;
    if (state_q == DONE) begin
      bus.o_arg = z_q[ZW-1:GUARD] + WIDTH'(z_q[GUARD-1]);
      bus.o_mag = x_q[WIDTH:0];
    end
  end

endmodule

// File: tb/tb_cordic_atan2_iter.sv
// tb/tb_cordic_atan2_iter.sv - randomized self-checking bench for cordic_atan2_iter
module tb_cordic_atan2_iter;
  localparam int  W     = 16;
  localparam int  ITER  = 16;
  localparam int  GUARD = 3;
  localparam real PI    = 3.14159265358979323846;
  localparam longint FULL = 64'd1 << W;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic clkena = 1'b1;

  always #5 clk = ~clk;

  cordic_atan2_iter_if #(.WIDTH(W)) bus ();

  cordic_atan2_iter #(.WIDTH(W), .ITER(ITER), .GUARD(GUARD)) dut (
    .clk    (clk),
    .reset  (reset),
    .clkena (clkena),
    .bus    (bus)
  );

  int  errors = 0;
  int  checks = 0;
  real kgain;

  task automatic check(input string tag, input longint obs, input longint exp,
                       input longint tol = 0, input bit circ = 0);
    longint d;
    checks++;
    d = obs - exp;
    if (circ) begin
      d = ((d % FULL) + FULL) % FULL;
      if (d > FULL / 2) d = FULL - d;
    end else if (d < 0) begin
      d = -d;
    end
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tolerance %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint ref_arg(input int c, input int s);
    real    r;
    longint v;
    if (c == 0 && s == 0) return 0;
    r = $atan2(real'(s), real'(c)) * real'(FULL) / (2.0 * PI);
    v = longint'(r);
    return ((v % FULL) + FULL) % FULL;
  endfunction

  function automatic longint ref_mag(input int c, input int s);
    return longint'(kgain * $sqrt(real'(c) * real'(c) + real'(s) * real'(s)));
  endfunction

  // One full transaction: offer, accept, wait (optionally with random clkena), optional backpressure, transfer.
  task automatic do_sample(input int c, input int s, input bit toggle, input int hold,
                           output longint arg, output longint mag);
    int lat;
    int dis;
    int n;
    bit got;
    arg = 0;
    mag = 0;
    @(negedge clk);
    bus.i_cos   = W'(c);
    bus.i_sin   = W'(s);
    bus.i_valid = 1'b1;
    bus.o_ready = 1'b0;
    clkena      = 1'b1;
    n = 0;
    while (!bus.i_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.i_ready) begin
      check("accept_timeout", 0, 1);
      bus.i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    dis = 0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_valid) begin
        got = 1'b1;
        break;
      end
      clkena = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!clkena) dis++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    clkena = 1'b1;
    check("result_timeout", longint'(got), 1);
    if (!got) return;
    check("latency", lat, ITER + 1 + dis);
    arg = bus.o_arg;
    mag = bus.o_mag;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("bp_stable", {bus.o_valid, bus.i_ready, bus.o_arg, bus.o_mag},
              {1'b1, 1'b0, W'(arg), 17'(mag)});
      end
      clkena      = 1'b0;
      bus.o_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ready_without_ena", longint'(bus.o_valid), 1);
      clkena = 1'b1;
    end
    bus.o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.o_ready = 1'b0;
    check("xfer_valid_low", longint'(bus.o_valid), 0);
    check("xfer_ready_high", longint'(bus.i_ready), 1);
  endtask

  int     dc [8] = '{16384, 0, -16384, 0, 11585, -32768, 0, -32768};
  int     ds [8] = '{0, 16384, 0, -16384, 11585, -32768, 0, 32767};
  longint mt [8] = '{8, 8, 8, 8, 8, 16, 0, 16};

  initial begin
    longint a, m, a2, m2;
    int     c, s, ph, hi_cnt;
    bus.i_valid = 1'b0;
    bus.i_cos   = '0;
    bus.i_sin   = '0;
    bus.o_ready = 1'b0;
    kgain = 1.0;
    for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));

    #3;
    check("rst_o_valid", longint'(bus.o_valid), 0);
    check("rst_i_ready", longint'(bus.i_ready), 0);
    check("rst_o_arg", longint'(bus.o_arg), 0);
    check("rst_o_mag", longint'(bus.o_mag), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_i_ready", longint'(bus.i_ready), 1);

    // Directed axes, diagonals, extremes and the zero vector; first one also exercises 20-cycle backpressure.
    for (int i = 0; i < 8; i++) begin
      do_sample(dc[i], ds[i], 1'b0, (i == 0) ? 20 : 0, a, m);
      check("dir_arg", a, ref_arg(dc[i], ds[i]), (dc[i] == 0 && ds[i] == 0) ? 0 : 4, 1'b1);
      check("dir_mag", m, ref_mag(dc[i], ds[i]), mt[i]);
    end

    // Random vectors of sufficient magnitude; some repeated with random clkena gaps.
    for (int i = 0; i < 60; i++) begin
      do begin
        c = int'($signed(16'($urandom)));
        s = int'($signed(16'($urandom)));
      end while (real'(c) * c + real'(s) * s < 8192.0 * 8192.0);
      do_sample(c, s, 1'b0, 0, a, m);
      check("rnd_arg", a, ref_arg(c, s), 4, 1'b1);
      check("rnd_mag", m, ref_mag(c, s), 16);
      if (i < 15) begin
        do_sample(c, s, 1'b1, 0, a2, m2);
        check("ena_arg_same", a2, a);
        check("ena_mag_same", m2, m);
      end
    end

    // Loop-back: phase -> ideal sin/cos ROM -> recovered phase, including the wrap region.
    for (int i = 0; i < 40; i++) begin
      case (i)
        0: ph = 0;
        1: ph = 1;
        2: ph = 65535;
        3: ph = 65534;
        4: ph = 32768;
        default: ph = int'($urandom_range(0, 65535));
      endcase
      c = int'(longint'(32767.0 * $cos(2.0 * PI * real'(ph) / real'(FULL))));
      s = int'(longint'(32767.0 * $sin(2.0 * PI * real'(ph) / real'(FULL))));
      do_sample(c, s, 1'b0, 0, a, m);
      check("loop_arg", a, ph, 4, 1'b1);
      check("loop_mag", m, ref_mag(c, s), 16);
    end

    // Asynchronous reset during rotation step 5: sample is dropped, block returns to IDLE.
    @(negedge clk);
    bus.i_cos   = W'(20000);
    bus.i_sin   = W'(-9000);
    bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_o_valid", longint'(bus.o_valid), 0);
    check("abort_i_ready", longint'(bus.i_ready), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_release_ready", longint'(bus.i_ready), 1);
    hi_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.o_valid) hi_cnt++;
    end
    check("abort_no_output", hi_cnt, 0);
    do_sample(-12000, 7000, 1'b0, 0, a, m);
    check("after_abort_arg", a, ref_arg(-12000, 7000), 4, 1'b1);
    check("after_abort_mag", m, ref_mag(-12000, 7000), 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
